// File: rtl/sync_fifo_flex.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_flex
//  Description : Single-clock FIFO with selectable registered or
//                first-word-fall-through read, occupancy count,
//                almost-full/almost-empty thresholds, synchronous flush and
//                sticky overflow/underflow flags.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo_flex #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AF_THRESH  = DEPTH - 4,
    parameter int unsigned AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH:0] c_level_full = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_af_thresh  = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] c_ae_thresh  = (ADDR_WIDTH+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Status is decoded purely from the registered count, so no request
    // input ever reaches a status output combinationally.
    assign w_full   = (r_level == c_level_full);
    assign w_empty  = (r_level == '0);
    assign w_wr_acc = wr_en & ~w_full;
    assign w_rd_acc = rd_en & ~w_empty;

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_level >= c_af_thresh);
    assign almost_empty = (r_level <= c_ae_thresh);
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Storage write; contents are not reset, and nothing lands during a flush.
    always_ff @(posedge clk) begin
        if (!rst && !clr && w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Occupancy counter: a simultaneous accepted write and read cancel out.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_level <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Sticky error flags, cleared only by reset or flush.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full)  r_overflow  <= 1'b1;
            if (rd_en && w_empty) r_underflow <= 1'b1;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; rd_en only acknowledges it.
            assign rd_data  = r_mem[r_rd_ptr];
            assign rd_valid = ~w_empty;
        end else begin : g_registered
            logic [DATA_WIDTH-1:0] r_rd_data;
            logic                  r_rd_valid;

            // One-cycle registered read; data holds across flush and idle cycles.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else if (clr) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

endmodule
`default_nettype wire
